// File: rtl/uart_frame_loader_if.sv
// Byte-stream input and SDRAM write-side-1 port bundle for uart_frame_loader.
// The slave modport is the loader; the master modport is the environment around it.
interface uart_frame_loader_if;
    logic [7:0]  iRX_DATA;
    logic        iRX_FLAG;
    logic [15:0] oWR_DATA;
    logic        oWR;
    logic [22:0] oWR_ADDR;
    logic [22:0] oWR_MAX_ADDR;
    logic        oWR_LOAD;
    logic        oBUSY;
    logic        oDONE;
    logic        oERR;
    logic [2:0]  oSLOT;
    logic [18:0] oCOUNT;

    modport slave (
        input  iRX_DATA, iRX_FLAG,
        output oWR_DATA, oWR, oWR_ADDR, oWR_MAX_ADDR, oWR_LOAD,
        output oBUSY, oDONE, oERR, oSLOT, oCOUNT
    );

    modport master (
        output iRX_DATA, iRX_FLAG,
        input  oWR_DATA, oWR, oWR_ADDR, oWR_MAX_ADDR, oWR_LOAD,
        input  oBUSY, oDONE, oERR, oSLOT, oCOUNT
    );
endinterface

// File: rtl/uart_frame_loader.sv
// Parses a sync/slot header from UART bytes, reloads the SDRAM write address to the
// chosen frame slot and streams pixel bytes as single-cycle write strobes.
module uart_frame_loader #(
    parameter int          PIXELS      = 307200,
    parameter logic [22:0] SLOT_STRIDE = 23'h04B000,
    parameter int          NUM_SLOTS   = 5,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int          LOAD_CYC    = 4,
    parameter int          TIMEOUT_CYC = 5_000_000
) (
    input logic                 iCLK,
    input logic                 iRST_N,
    uart_frame_loader_if.slave  bus
);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       LOAD_LAST   = 4'(LOAD_CYC);
    localparam logic [18:0]      PIX_LAST    = 19'(PIXELS);
    localparam logic [22:0]      PIX_SPAN    = 23'(PIXELS);
    localparam logic [7:0]       NUM_SLOTS_B = 8'(NUM_SLOTS);

    logic [2:0]       state;
    logic [TMR_W-1:0] timer;
    logic [3:0]       load_cnt;
    logic             pend_vld;
    logic [7:0]       pend_data;
    logic [2:0]       hdr_slot;
    logic [15:0]      wr_data;
    logic             wr;
    logic             wr_load;
    logic [22:0]      wr_addr;
    logic [22:0]      wr_max;
    logic             err;
    logic [2:0]       slot;
    logic [18:0]      count;

    logic        flag;
    logic [7:0]  rx;
    logic        slot_ok;
    logic        expired;
    logic [22:0] base_addr;
    logic [18:0] count_inc;

    assign flag      = bus.iRX_FLAG;
    assign rx        = bus.iRX_DATA;
    assign slot_ok   = rx < NUM_SLOTS_B;
    assign expired   = timer == TMR_LAST;
    assign base_addr = {15'd0, rx} * SLOT_STRIDE;
    assign count_inc = count + 19'd1;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= S_IDLE;
            timer     <= '0;
            load_cnt  <= '0;
            pend_vld  <= 1'b0;
            pend_data <= '0;
            hdr_slot  <= '0;
            wr_data   <= '0;
            wr        <= 1'b0;
            wr_load   <= 1'b0;
            wr_addr   <= '0;
            wr_max    <= PIX_SPAN;
            err       <= 1'b0;
            slot      <= '0;
            count     <= '0;
        end else begin
            wr      <= 1'b0;
            wr_load <= 1'b0;
            timer   <= timer + 1'b1;
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (flag && rx == SYNC_BYTE)
                        state <= S_HDR;
                end
                S_HDR: begin
                    if (flag) begin
                        timer <= '0;
                        if (slot_ok) begin
                            wr_addr  <= base_addr;
                            wr_max   <= base_addr + PIX_SPAN;
                            err      <= 1'b0;
                            count    <= '0;
                            hdr_slot <= rx[2:0];
                            load_cnt <= '0;
                            pend_vld <= 1'b0;
                            state    <= S_LOAD;
                        end else begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else if (expired) begin
                        err   <= 1'b1;
                        timer <= '0;
                        state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    // A byte landing while the address reloads is parked, then
                    // flushed as the very first strobe when DATA begins.
                    if (flag) begin
                        pend_vld  <= 1'b1;
                        pend_data <= rx;
                    end
                    if (load_cnt == LOAD_LAST) begin
                        state    <= S_DATA;
                        timer    <= '0;
                        pend_vld <= 1'b0;
                        if (flag || pend_vld) begin
                            wr      <= 1'b1;
                            wr_data <= {8'h00, flag ? rx : pend_data};
                            count   <= count_inc;
                            if (count_inc == PIX_LAST)
                                state <= S_DONE;
                        end
                    end else if (!flag && expired) begin
                        err   <= 1'b1;
                        timer <= '0;
                        state <= S_IDLE;
                    end else begin
                        wr_load  <= 1'b1;
                        load_cnt <= load_cnt + 1'b1;
                        if (flag)
                            timer <= '0;
                    end
                end
                S_DATA: begin
                    // A received byte beats a simultaneous timer expiry.
                    if (flag) begin
                        timer   <= '0;
                        wr      <= 1'b1;
                        wr_data <= {8'h00, rx};
                        count   <= count_inc;
                        if (count_inc == PIX_LAST)
                            state <= S_DONE;
                    end else if (expired) begin
                        err   <= 1'b1;
                        timer <= '0;
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    slot  <= hdr_slot;
                    timer <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.oWR_DATA     = wr_data;
    assign bus.oWR          = wr;
    assign bus.oWR_ADDR     = wr_addr;
    assign bus.oWR_MAX_ADDR = wr_max;
    assign bus.oWR_LOAD     = wr_load;
    assign bus.oBUSY        = state != S_IDLE;
    assign bus.oDONE        = state == S_DONE;
    assign bus.oERR         = err;
    assign bus.oSLOT        = slot;
    assign bus.oCOUNT       = count;
endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader with a write-data scoreboard queue.
module tb_uart_frame_loader;
    localparam int GAP0 = 434;
    localparam int GAP  = 20;

    logic clk = 1'b0;
    logic rst_n;
    uart_frame_loader_if bus();

    uart_frame_loader #(.PIXELS(16), .TIMEOUT_CYC(1000)) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int wr_cnt     = 0;
    int load_cnt   = 0;
    int done_cnt   = 0;
    logic [15:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic exp_wr, input int gap);
        repeat (gap) @(posedge clk);
        #1;
        bus.iRX_DATA = b;
        bus.iRX_FLAG = 1'b1;
        if (exp_wr) sb.push_back({8'h00, b});
        @(posedge clk);
        #1 bus.iRX_FLAG = 1'b0;
        @(negedge clk);
        chk("wr_latency", 32'(bus.oWR), 32'(exp_wr));
    endtask

    task automatic clear_counts();
        wr_cnt   = 0;
        load_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic check_done(input string tag, input logic [2:0] s);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({tag, "_wr_cnt"}, 32'(wr_cnt), 16);
        chk({tag, "_done_cnt"}, 32'(done_cnt), 1);
        chk({tag, "_slot"}, 32'(bus.oSLOT), 32'(s));
        chk({tag, "_busy"}, 32'(bus.oBUSY), 0);
        chk({tag, "_count"}, 32'(bus.oCOUNT), 16);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 0);
    endtask

    always @(negedge clk) begin
        if (bus.oWR_LOAD) load_cnt++;
        if (bus.oDONE) done_cnt++;
        if (bus.oWR) begin
            wr_cnt++;
            chk("wr_excl_load", 32'(bus.oWR_LOAD), 0);
            chk("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) chk("wr_data", 32'(bus.oWR_DATA), 32'(sb.pop_front()));
        end
    end

    initial begin
        logic [7:0] b;
        bus.iRX_DATA = 8'h00;
        bus.iRX_FLAG = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr", 32'(bus.oWR), 0);
        chk("rst_load", 32'(bus.oWR_LOAD), 0);
        chk("rst_busy", 32'(bus.oBUSY), 0);
        chk("rst_err", 32'(bus.oERR), 0);
        chk("rst_addr", 32'(bus.oWR_ADDR), 0);
        chk("rst_max", 32'(bus.oWR_MAX_ADDR), 32'h10);
        chk("rst_count", 32'(bus.oCOUNT), 0);
        rst_n = 1'b1;

        // Nominal frame into slot 2 at UART byte spacing
        clear_counts();
        send(8'hA5, 1'b0, GAP0);
        chk("sync_busy", 32'(bus.oBUSY), 1);
        send(8'h02, 1'b0, GAP0);
        chk("s2_addr", 32'(bus.oWR_ADDR), 32'h096000);
        chk("s2_max", 32'(bus.oWR_MAX_ADDR), 32'h096010);
        chk("s2_load_not_yet", 32'(bus.oWR_LOAD), 0);
        for (int i = 0; i < 16; i++) send(8'(i), 1'b1, GAP0);
        check_done("s2", 3'd2);
        chk("s2_load_cycles", 32'(load_cnt), 4);

        // Noise bytes ignored, invalid slot flags an error
        clear_counts();
        send(8'h11, 1'b0, GAP);
        chk("noise_idle", 32'(bus.oBUSY), 0);
        send(8'h22, 1'b0, GAP);
        send(8'hA5, 1'b0, GAP);
        send(8'h07, 1'b0, GAP);
        chk("bad_slot_err", 32'(bus.oERR), 1);
        chk("bad_slot_idle", 32'(bus.oBUSY), 0);
        repeat (8) @(posedge clk);
        chk("bad_slot_no_load", 32'(load_cnt), 0);
        send(8'hA5, 1'b0, GAP);
        send(8'h00, 1'b0, GAP);
        chk("s0_err_clr", 32'(bus.oERR), 0);
        chk("s0_addr", 32'(bus.oWR_ADDR), 0);
        for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1'b1, GAP);
        check_done("s0", 3'd0);

        // Byte arriving during address reload is held then written first
        clear_counts();
        send(8'hA5, 1'b0, GAP);
        repeat (GAP) @(posedge clk);
        #1;
        bus.iRX_DATA = 8'h01;
        bus.iRX_FLAG = 1'b1;
        @(posedge clk);
        #1;
        bus.iRX_DATA = 8'h5A;
        sb.push_back(16'h005A);
        @(posedge clk);
        #1 bus.iRX_FLAG = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pend_held", 32'(bus.oWR), 0);
        chk("pend_load_hi", 32'(bus.oWR_LOAD), 1);
        @(posedge clk);
        @(negedge clk);
        chk("pend_written", 32'(bus.oWR), 1);
        chk("pend_load_lo", 32'(bus.oWR_LOAD), 0);
        chk("pend_count", 32'(bus.oCOUNT), 1);
        for (int i = 0; i < 15; i++) send(8'(8'h60 + i), 1'b1, GAP);
        check_done("s1", 3'd1);

        // Silence after 5 bytes expires the timer
        clear_counts();
        send(8'hA5, 1'b0, GAP);
        send(8'h04, 1'b0, GAP);
        for (int i = 0; i < 5; i++) send(8'(8'h80 + i), 1'b1, GAP);
        repeat (999) @(posedge clk);
        @(negedge clk);
        chk("to_not_early", 32'(bus.oERR), 0);
        @(posedge clk);
        @(negedge clk);
        chk("to_err", 32'(bus.oERR), 1);
        chk("to_idle", 32'(bus.oBUSY), 0);
        chk("to_count", 32'(bus.oCOUNT), 5);
        chk("to_no_done", 32'(done_cnt), 0);

        // Byte in the expiry cycle wins over the timeout
        clear_counts();
        send(8'hA5, 1'b0, GAP);
        send(8'h04, 1'b0, GAP);
        for (int i = 0; i < 5; i++) send(8'(8'h90 + i), 1'b1, GAP);
        repeat (999) @(posedge clk);
        #1;
        bus.iRX_DATA = 8'h77;
        bus.iRX_FLAG = 1'b1;
        sb.push_back(16'h0077);
        @(posedge clk);
        #1 bus.iRX_FLAG = 1'b0;
        @(negedge clk);
        chk("race_no_err", 32'(bus.oERR), 0);
        chk("race_wr", 32'(bus.oWR), 1);
        chk("race_count", 32'(bus.oCOUNT), 6);
        chk("race_busy", 32'(bus.oBUSY), 1);
        for (int i = 0; i < 10; i++) send(8'(8'hB0 + i), 1'b1, GAP);
        check_done("s4", 3'd4);

        // Sync value inside the payload is plain pixel data
        clear_counts();
        send(8'hA5, 1'b0, GAP);
        send(8'h03, 1'b0, GAP);
        for (int i = 0; i < 16; i++) begin
            b = (i == 3 || i == 9) ? 8'hA5 : 8'(8'h30 + i);
            send(b, 1'b1, GAP);
        end
        check_done("s3", 3'd3);

        // Asynchronous reset mid-frame, then a clean frame
        clear_counts();
        send(8'hA5, 1'b0, GAP);
        send(8'h00, 1'b0, GAP);
        for (int i = 0; i < 8; i++) send(8'(8'hC0 + i), 1'b1, GAP);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.oBUSY), 0);
        chk("arst_count", 32'(bus.oCOUNT), 0);
        chk("arst_slot", 32'(bus.oSLOT), 0);
        chk("arst_data", 32'(bus.oWR_DATA), 0);
        chk("arst_max", 32'(bus.oWR_MAX_ADDR), 32'h10);
        chk("arst_sb_empty", 32'(sb.size()), 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        clear_counts();
        send(8'hA5, 1'b0, GAP);
        send(8'h00, 1'b0, GAP);
        for (int i = 0; i < 16; i++) send(8'(8'hD0 + i), 1'b1, GAP);
        check_done("post_rst", 3'd0);
        chk("post_rst_max", 32'(bus.oWR_MAX_ADDR), 32'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
Controller sequencing UART-received image frames into the SDRAM frame buffer through the Sdram_Control write-side-1 FIFO port. It sits between uart_rx (po_data/po_flag) and Sdram_Control WR1_*. It parses a sync/slot header, re-bases the write address to the selected frame slot, streams pixel bytes as write strobes, and reports completion, abort and timeout.

Parameters:
PIXELS, 307200, bytes per frame (640*480); frame complete after this many data bytes
SLOT_STRIDE, 23'h04B000, address distance between frame slots
NUM_SLOTS, 5, valid slot indices 0..NUM_SLOTS-1
SYNC_BYTE, 8'hA5, frame start marker
LOAD_CYC, 4, cycles oWR_LOAD is held high before data (1..15)
TIMEOUT_CYC, 5_000_000, idle cycles between header/data bytes before abort (100 ms at 50 MHz)

Ports:
iCLK  in  1  system clock (50 MHz, same domain as uart_rx)
iRST_N  in  1  asynchronous active-low reset
iRX_DATA  in  8  received byte, valid when iRX_FLAG=1
iRX_FLAG  in  1  one-cycle byte-valid pulse
oWR_DATA  out  16  {8'h00, byte} to WR1_DATA
oWR  out  1  one-cycle write strobe to WR1
oWR_ADDR  out  23  slot base address to WR1_ADDR
oWR_MAX_ADDR  out  23  oWR_ADDR+PIXELS to WR1_MAX_ADDR
oWR_LOAD  out  1  address reload to WR1_LOAD
oBUSY  out  1  high in every state except IDLE
oDONE  out  1  one-cycle pulse on frame completion
oERR  out  1  sticky error flag
oSLOT  out  3  index of last completed slot
oCOUNT  out  19  data bytes accepted in current frame

Behaviour:
- Reset (async, iRST_N=0): state IDLE; all outputs 0 except oWR_MAX_ADDR=PIXELS; pending buffer, timer and counter cleared. Reset mid-frame abandons the frame with no further strobes.
- IDLE: iRX_FLAG with iRX_DATA==SYNC_BYTE -> HDR. Every other byte is ignored. No timeout in IDLE.
- HDR: next byte is the slot index s.
  - If s<NUM_SLOTS: oWR_ADDR<=s*SLOT_STRIDE (23-bit, registered), oWR_MAX_ADDR<=s*SLOT_STRIDE+PIXELS, oERR<=0, oCOUNT<=0, then -> LOAD.
  - If s>=NUM_SLOTS: oERR<=1, -> IDLE.
- LOAD: oWR_LOAD=1 for exactly LOAD_CYC cycles, starting the cycle after the address registers update, then -> DATA.
  - A byte arriving during LOAD goes into a one-entry pending register.
  - That byte is written on the first DATA cycle.
- DATA: each accepted byte produces oWR=1 for one cycle, with oWR_DATA={8'h00,byte}, in the cycle after iRX_FLAG (1-cycle latency). oCOUNT increments in the same cycle as oWR.
  - When the PIXELS-th strobe issues: -> DONE.
  - A SYNC_BYTE value inside DATA is pixel data, not a resync.
- DONE: one cycle. oDONE=1, oSLOT<=header slot, -> IDLE. A byte arriving in the DONE cycle is discarded.
- Timeout (HDR, LOAD, DATA): the timer clears on every iRX_FLAG and on state entry.
  - When the timer reaches TIMEOUT_CYC-1: oERR<=1, -> IDLE, oCOUNT holds its value for debug.
  - If iRX_FLAG and timer expiry occur in the same cycle, the byte wins: it is processed and the timer clears.
- oERR stays set until the next valid header is accepted.
- No write strobe is ever issued outside DATA. oWR and oWR_LOAD are never high in the same cycle.
- Counter is 19 bits. The timer width is sized for TIMEOUT_CYC.

Test Plan:
- Bench parameters PIXELS=16, TIMEOUT_CYC=1000. Send A5,02 + 16 bytes 00..0F at 434-cycle spacing -> oWR_ADDR=0x096000, oWR_MAX_ADDR=0x096010, oWR_LOAD high 4 cycles, 16 oWR pulses each 1 cycle after iRX_FLAG with oWR_DATA=0x0000..0x000F, oDONE one pulse, oSLOT=2, oBUSY=0 afterward.
- Bytes 11,22,A5,07 -> 11 and 22 ignored, slot 7 invalid -> oERR=1, no oWR_LOAD, state IDLE. Then A5,00 -> oERR cleared, oWR_ADDR=0.
- A5,01, then a data byte driven 1 cycle after LOAD entry -> byte held, written on first DATA cycle, oCOUNT=1, no byte lost.
- A5,04 + 5 bytes, then silence -> oERR=1 exactly 1000 cycles after the last byte, oCOUNT=5, no oDONE. A byte arriving in the expiry cycle instead -> no error, oCOUNT=6.
- A5,03 + 16 bytes including 0xA5 at positions 3 and 9 -> treated as data, 16 strobes, oDONE, oSLOT=3.
- Assert iRST_N=0 after 8 data bytes -> all outputs zero asynchronously, oWR_MAX_ADDR=16. After release, the next frame A5,00 + 16 bytes completes normally.
